// File: rtl/gray_sched_pkg.sv
// gray_sched_pkg
// Shared definitions for the gray-code conversion scheduler:
//   - register address map of the TinyQV byte-peripheral window
//   - STATUS register bit positions
//   - scheduler FSM states, converter modes and requester identifiers
// Optional feature macro used by the including files: GRAY_SCHED_PMOD_EN.
package gray_sched_pkg;

    // Register addresses
    localparam logic [3:0] ADDR_STATUS = 4'h0;  // read STATUS, write CLEAR
    localparam logic [3:0] ADDR_B2G    = 4'h1;  // write: CPU job, bin->gray
    localparam logic [3:0] ADDR_G2B    = 4'h2;  // write: CPU job, gray->bin
    localparam logic [3:0] ADDR_RESULT = 4'h3;  // read: CPU result
    localparam logic [3:0] ADDR_POS    = 4'h4;  // read: PMOD position
    localparam logic [3:0] ADDR_CTRL   = 4'h6;  // read/write: CTRL

    // STATUS bit indices
    localparam int ST_BUSY      = 0;
    localparam int ST_OWNER     = 1;
    localparam int ST_CPU_PEND  = 2;
    localparam int ST_PMOD_PEND = 3;
    localparam int ST_CPU_DONE  = 4;
    localparam int ST_OVERRUN   = 5;

    // Number of converter steps per job (one bit per cycle)
    localparam int CONV_BITS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } sched_state_e;

    typedef enum logic {
        BIN2GRAY = 1'b0,
        GRAY2BIN = 1'b1
    } conv_mode_e;

    typedef enum logic {
        REQ_CPU  = 1'b0,
        REQ_PMOD = 1'b1
    } req_id_e;

    // Chooses the converter mode from the CPU job address.
    function automatic conv_mode_e job_mode(input logic [3:0] addr);
        return (addr == ADDR_G2B) ? GRAY2BIN : BIN2GRAY;
    endfunction

endpackage

// File: rtl/gray_serial_conv.sv
// gray_serial_conv
// Bit-serial Gray/binary converter. A job is loaded with start and then
// processes one bit per cycle, MSB first, through bit indices 7..0.
//   clk, rst : clock, synchronous active-high reset
//   start    : load din/mode and begin at bit index 7
//   abort    : drop the job in flight
//   mode     : BIN2GRAY or GRAY2BIN
//   din      : job operand
//   dout     : result including the bit being processed this cycle
//              (complete while done is high)
//   done     : high during the cycle that processes bit 0
module gray_serial_conv
    import gray_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  conv_mode_e mode,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       done
);

    logic       active_q, active_d;
    conv_mode_e mode_q,   mode_d;
    logic [7:0] din_q,    din_d;
    logic [7:0] out_q,    out_d;
    logic [2:0] idx_q,    idx_d;
    logic       prev_q,   prev_d;
    logic       cur_bit;

    // prev_q holds in[k+1] for bin->gray and out[k+1] for gray->bin, so both
    // modes reduce to a single XOR with the operand bit.
    always_comb begin
        cur_bit     = din_q[idx_q] ^ prev_q;
        dout        = out_q;
        dout[idx_q] = cur_bit;
        done        = active_q && (idx_q == 3'd0);
    end

    always_comb begin
        active_d = active_q;
        mode_d   = mode_q;
        din_d    = din_q;
        out_d    = out_q;
        idx_d    = idx_q;
        prev_d   = prev_q;
        if (abort) begin
            active_d = 1'b0;
        end else if (start) begin
            active_d = 1'b1;
            mode_d   = mode;
            din_d    = din;
            out_d    = 8'h00;
            idx_d    = 3'd7;
            prev_d   = 1'b0;
        end else if (active_q) begin
            out_d[idx_q] = cur_bit;
            prev_d       = (mode_q == BIN2GRAY) ? din_q[idx_q] : cur_bit;
            if (idx_q == 3'd0) begin
                active_d = 1'b0;
            end else begin
                idx_d = idx_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            mode_q   <= BIN2GRAY;
            din_q    <= 8'h00;
            out_q    <= 8'h00;
            idx_q    <= 3'd0;
            prev_q   <= 1'b0;
        end else begin
            active_q <= active_d;
            mode_q   <= mode_d;
            din_q    <= din_d;
            out_q    <= out_d;
            idx_q    <= idx_d;
            prev_q   <= prev_d;
        end
    end

endmodule

// File: rtl/tqvp_gera_gray_sched.sv
// tqvp_gera_gray_sched
// Conversion scheduler for the gray-code peripheral. One bit-serial
// converter is shared between CPU register jobs and a PMOD absolute-encoder
// sampler; each requester queues one job, ties are resolved round-robin.
//   clk, rst    : 64 MHz clock, synchronous active-high reset
//   ui_in       : PMOD input, bits 6:0 encoder gray position
//   uo_out      : CPU result register
//   address     : register address
//   data_write  : write strobe
//   data_in     : write data
//   data_out    : read data, combinational on address
// Macro GRAY_SCHED_PMOD_EN builds the PMOD requester, position register,
// CTRL and round-robin arbitration; without it the block is CPU-only.
module tqvp_gera_gray_sched
    import gray_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    // Scheduler state
    sched_state_e state_q, state_d;
    req_id_e      owner_q, owner_d;

    // CPU requester and register file
    logic         cpu_pending_q, cpu_pending_d;
    logic [7:0]   cpu_data_q,    cpu_data_d;
    conv_mode_e   cpu_mode_q,    cpu_mode_d;
    logic         cpu_done_q,    cpu_done_d;
    logic         overrun_q,     overrun_d;
    logic [7:0]   cpu_result_q,  cpu_result_d;

    // Decode, arbitration and converter hookup
    logic         wr_clear, wr_job, job_accept;
    logic         cpu_in_flight, cpu_complete, cpu_abort;
    logic         cpu_req, pmod_req;
    logic         grant_cpu, grant_pmod;
    logic         conv_start, conv_done;
    conv_mode_e   conv_mode;
    logic [7:0]   conv_din, conv_dout;
    logic         pmod_pending_bit, owner_bit;
    logic [7:0]   status;

`ifdef GRAY_SCHED_PMOD_EN
    logic         pmod_en_q,      pmod_en_d;
    logic [6:0]   last_sample_q,  last_sample_d;
    logic [6:0]   pmod_job_q,     pmod_job_d;
    logic         pmod_pending_q, pmod_pending_d;
    logic [6:0]   pos_q,          pos_d;
    req_id_e      last_grant_q,   last_grant_d;
    logic         wr_ctrl, pmod_complete;
    logic         unused_ui;
    assign unused_ui = ui_in[7];
`else
    logic         unused_ui;
    assign unused_ui = ^ui_in;
`endif

    // Bus decode. A CPU job write is accepted unless a job is already queued
    // or a CPU job is still converting; finishing this very cycle frees it.
    always_comb begin
        wr_clear      = data_write && (address == ADDR_STATUS);
        wr_job        = data_write && ((address == ADDR_B2G) || (address == ADDR_G2B));
        cpu_in_flight = (state_q == CONV) && (owner_q == REQ_CPU);
        cpu_complete  = cpu_in_flight && conv_done;
        cpu_abort     = cpu_in_flight && wr_clear;
        job_accept    = wr_job && !(cpu_pending_q || (cpu_in_flight && !conv_done));
    end

    // Arbiter: only grants from IDLE. A CLEAR in the same cycle cancels the
    // queued CPU job, and disabling the PMOD cancels its queued job.
    always_comb begin
        cpu_req    = cpu_pending_q && !wr_clear;
        pmod_req   = 1'b0;
        grant_cpu  = 1'b0;
        grant_pmod = 1'b0;
`ifdef GRAY_SCHED_PMOD_EN
        pmod_req = pmod_pending_q && pmod_en_q && !(wr_ctrl && !data_in[0]);
        if (state_q == IDLE) begin
            if (cpu_req && pmod_req) begin
                if (last_grant_q == REQ_PMOD) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_pmod = 1'b1;
                end
            end else if (cpu_req) begin
                grant_cpu = 1'b1;
            end else if (pmod_req) begin
                grant_pmod = 1'b1;
            end
        end
`else
        if (state_q == IDLE) begin
            grant_cpu = cpu_req;
        end
`endif
        conv_start = grant_cpu || grant_pmod;
    end

    // Converter operand selection
    always_comb begin
        conv_mode = cpu_mode_q;
        conv_din  = cpu_data_q;
`ifdef GRAY_SCHED_PMOD_EN
        if (grant_pmod) begin
            conv_mode = GRAY2BIN;
            conv_din  = {1'b0, pmod_job_q};
        end
`endif
    end

    gray_serial_conv u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .abort (cpu_abort),
        .mode  (conv_mode),
        .din   (conv_din),
        .dout  (conv_dout),
        .done  (conv_done)
    );

    // FSM next state: the converter tracks the bit index, the FSM only marks
    // which requester owns the converter.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (conv_start) begin
                    state_d = CONV;
                    owner_d = grant_pmod ? REQ_PMOD : REQ_CPU;
                end
            end
            CONV: begin
                if (cpu_abort || conv_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // CPU requester. CLEAR is applied last so it overrides completion.
    always_comb begin
        cpu_pending_d = cpu_pending_q;
        cpu_data_d    = cpu_data_q;
        cpu_mode_d    = cpu_mode_q;
        cpu_done_d    = cpu_done_q;
        overrun_d     = overrun_q;
        cpu_result_d  = cpu_result_q;
        if (grant_cpu) begin
            cpu_pending_d = 1'b0;
        end
        if (cpu_complete) begin
            cpu_result_d = conv_dout;
            cpu_done_d   = 1'b1;
        end
        if (job_accept) begin
            cpu_pending_d = 1'b1;
            cpu_data_d    = data_in;
            cpu_mode_d    = job_mode(address);
            cpu_done_d    = 1'b0;
        end else if (wr_job) begin
            overrun_d = 1'b1;
        end
        if (wr_clear) begin
            cpu_result_d  = 8'h00;
            cpu_pending_d = 1'b0;
            cpu_done_d    = 1'b0;
            overrun_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            owner_q       <= REQ_CPU;
            cpu_pending_q <= 1'b0;
            cpu_data_q    <= 8'h00;
            cpu_mode_q    <= BIN2GRAY;
            cpu_done_q    <= 1'b0;
            overrun_q     <= 1'b0;
            cpu_result_q  <= 8'h00;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cpu_pending_q <= cpu_pending_d;
            cpu_data_q    <= cpu_data_d;
            cpu_mode_q    <= cpu_mode_d;
            cpu_done_q    <= cpu_done_d;
            overrun_q     <= overrun_d;
            cpu_result_q  <= cpu_result_d;
        end
    end

`ifdef GRAY_SCHED_PMOD_EN
    // PMOD requester: a changed sample replaces any queued job (latest wins).
    // Enabling reloads the reference sample so the current position is not
    // treated as a change.
    always_comb begin
        wr_ctrl        = data_write && (address == ADDR_CTRL);
        pmod_complete  = (state_q == CONV) && (owner_q == REQ_PMOD) && conv_done;
        pmod_en_d      = pmod_en_q;
        last_sample_d  = last_sample_q;
        pmod_job_d     = pmod_job_q;
        pmod_pending_d = pmod_pending_q;
        pos_d          = pos_q;
        last_grant_d   = last_grant_q;
        if (grant_cpu) begin
            last_grant_d = REQ_CPU;
        end
        if (grant_pmod) begin
            last_grant_d   = REQ_PMOD;
            pmod_pending_d = 1'b0;
        end
        if (pmod_complete) begin
            pos_d = conv_dout[6:0];
        end
        if (pmod_en_q && (ui_in[6:0] != last_sample_q)) begin
            last_sample_d  = ui_in[6:0];
            pmod_job_d     = ui_in[6:0];
            pmod_pending_d = 1'b1;
        end
        if (wr_ctrl) begin
            pmod_en_d = data_in[0];
            if (!data_in[0]) begin
                pmod_pending_d = 1'b0;
            end else if (!pmod_en_q) begin
                last_sample_d = ui_in[6:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pmod_en_q      <= 1'b0;
            last_sample_q  <= 7'h00;
            pmod_job_q     <= 7'h00;
            pmod_pending_q <= 1'b0;
            pos_q          <= 7'h00;
            last_grant_q   <= REQ_PMOD;
        end else begin
            pmod_en_q      <= pmod_en_d;
            last_sample_q  <= last_sample_d;
            pmod_job_q     <= pmod_job_d;
            pmod_pending_q <= pmod_pending_d;
            pos_q          <= pos_d;
            last_grant_q   <= last_grant_d;
        end
    end
`endif

    // Read mux. The owner bit is only meaningful while busy, so it reads 0
    // when the converter is idle.
    always_comb begin
`ifdef GRAY_SCHED_PMOD_EN
        pmod_pending_bit = pmod_pending_q;
        owner_bit        = (state_q == CONV) && (owner_q == REQ_PMOD);
`else
        pmod_pending_bit = 1'b0;
        owner_bit        = 1'b0;
`endif
        status               = 8'h00;
        status[ST_BUSY]      = (state_q == CONV);
        status[ST_OWNER]     = owner_bit;
        status[ST_CPU_PEND]  = cpu_pending_q;
        status[ST_PMOD_PEND] = pmod_pending_bit;
        status[ST_CPU_DONE]  = cpu_done_q;
        status[ST_OVERRUN]   = overrun_q;

        data_out = 8'h00;
        case (address)
            ADDR_STATUS: data_out = status;
            ADDR_RESULT: data_out = cpu_result_q;
`ifdef GRAY_SCHED_PMOD_EN
            ADDR_POS:    data_out = {1'b0, pos_q};
            ADDR_CTRL:   data_out = {7'b0, pmod_en_q};
`endif
            default:     data_out = 8'h00;
        endcase
        uo_out = cpu_result_q;
    end

endmodule

// File: tb/tb_tqvp_gera_gray_sched.sv
// tb_tqvp_gera_gray_sched
// Self-checking bench for the gray-code conversion scheduler: directed
// scenarios against fixed expected values plus a randomized run against a
// transaction-level reference model. Honours GRAY_SCHED_PMOD_EN.
module tb_tqvp_gera_gray_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_err = 0;

    tqvp_gera_gray_sched dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Reference model: jobs computed arithmetically at grant, completion
    // after a fixed 8-edge countdown.
    logic       m_busy, m_owner, m_last_grant;
    int         m_rem;
    logic [7:0] m_res;
    logic       m_cpu_pend, m_cpu_mode, m_cpu_done, m_overrun;
    logic [7:0] m_cpu_data, m_result;
    logic       m_pmod_en, m_pmod_pend;
    logic [6:0] m_last, m_pmod_job, m_pos;

    function automatic logic [7:0] ref_b2g(input logic [7:0] x);
        return x ^ (x >> 1);
    endfunction

    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        b = 8'h00;
        for (int s = 0; s < 8; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic logic [7:0] m_status();
        return {2'b00, m_overrun, m_cpu_done, m_pmod_pend, m_cpu_pend,
                m_busy & m_owner, m_busy};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_last_grant = 1; m_rem = 0; m_res = 0;
        m_cpu_pend = 0; m_cpu_mode = 0; m_cpu_done = 0; m_overrun = 0;
        m_cpu_data = 0; m_result = 0;
        m_pmod_en = 0; m_pmod_pend = 0; m_last = 0; m_pmod_job = 0; m_pos = 0;
    endtask

    task automatic model_step();
        logic clr, wj, ctrl, completing, cpu_inflight, cpu_req, pmod_req;
        logic gc, gp, accept, pmod_change;
        if (rst) begin
            model_reset();
            return;
        end
        clr          = data_write && (address == 4'h0);
        wj           = data_write && (address == 4'h1 || address == 4'h2);
        ctrl         = data_write && (address == 4'h6);
        completing   = m_busy && (m_rem == 1);
        cpu_inflight = m_busy && !m_owner;
        cpu_req      = m_cpu_pend && !clr;
        pmod_req     = m_pmod_pend && m_pmod_en && !(ctrl && !data_in[0]);
        gc = 0; gp = 0;
        if (!m_busy) begin
            if (cpu_req && pmod_req) begin
                if (m_last_grant) gc = 1; else gp = 1;
            end else if (cpu_req) gc = 1;
            else if (pmod_req) gp = 1;
        end
        accept      = wj && !(m_cpu_pend || (cpu_inflight && !completing));
        pmod_change = m_pmod_en && (ui_in[6:0] != m_last);

        if (m_busy) begin
            if (cpu_inflight && clr) m_busy = 0;
            else if (completing) begin
                m_busy = 0;
                if (!m_owner) begin
                    m_result   = m_res;
                    m_cpu_done = 1;
                end else m_pos = m_res[6:0];
            end else m_rem = m_rem - 1;
        end else if (gc || gp) begin
            m_busy = 1; m_rem = 8; m_owner = gp; m_last_grant = gp;
            if (gc) begin
                m_res = m_cpu_mode ? ref_g2b(m_cpu_data) : ref_b2g(m_cpu_data);
                m_cpu_pend = 0;
            end else begin
                m_res = ref_g2b({1'b0, m_pmod_job});
                m_pmod_pend = 0;
            end
        end
        if (accept) begin
            m_cpu_pend = 1; m_cpu_data = data_in;
            m_cpu_mode = (address == 4'h2); m_cpu_done = 0;
        end else if (wj) m_overrun = 1;
`ifdef GRAY_SCHED_PMOD_EN
        if (pmod_change) begin
            m_last = ui_in[6:0]; m_pmod_job = ui_in[6:0]; m_pmod_pend = 1;
        end
        if (ctrl) begin
            if (!data_in[0]) m_pmod_pend = 0;
            else if (!m_pmod_en) m_last = ui_in[6:0];
            m_pmod_en = data_in[0];
        end
`else
        if (pmod_change || ctrl) m_pmod_pend = 0;
`endif
        if (clr) begin
            m_result = 0; m_cpu_pend = 0; m_cpu_done = 0; m_overrun = 0;
        end
    endtask

    // One clock edge; the model consumes the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        address = a; data_in = d; data_write = 1'b1;
        tick();
        data_write = 1'b0; address = 4'h0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] v);
        address = a; data_write = 1'b0;
        #1;
        v = data_out;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("[TB] FAIL reset_status: got %02h expected 00", v); end
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("[TB] FAIL reset_result: got %02h expected 00", v); end
        bus_read(4'h4, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("[TB] FAIL reset_pos: got %02h expected 00", v); end
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("[TB] FAIL reset_uo: got %02h expected 00", uo_out); end
    endtask

    task automatic test_cpu_b2g();
        logic [7:0] v;
        bus_write(4'h1, 8'h5A);
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h04) begin n_err++; $display("[TB] FAIL b2g_pending: got %02h expected 04", v); end
        tick();
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h01) begin n_err++; $display("[TB] FAIL b2g_busy: got %02h expected 01", v); end
        ticks(8);
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'h77) begin n_err++; $display("[TB] FAIL b2g_result: got %02h expected 77", v); end
        n_cmp++;
        if (uo_out !== 8'h77) begin n_err++; $display("[TB] FAIL b2g_uo: got %02h expected 77", uo_out); end
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h10) begin n_err++; $display("[TB] FAIL b2g_status: got %02h expected 10", v); end
    endtask

    task automatic test_overrun();
        logic [7:0] v;
        bus_write(4'h2, 8'h77);
        tick();
        bus_write(4'h1, 8'h12);
        ticks(7);
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'h5A) begin n_err++; $display("[TB] FAIL ovr_result: got %02h expected 5a", v); end
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h30) begin n_err++; $display("[TB] FAIL ovr_status: got %02h expected 30", v); end
    endtask

    task automatic test_clear_abort();
        logic [7:0] v;
        bus_write(4'h0, 8'h00);
        bus_write(4'h1, 8'h33);
        ticks(3);
        bus_write(4'h0, 8'h00);
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("[TB] FAIL clr_status: got %02h expected 00", v); end
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("[TB] FAIL clr_uo: got %02h expected 00", uo_out); end
        bus_write(4'h2, 8'hC3);
        ticks(9);
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'h82) begin n_err++; $display("[TB] FAIL clr_next_result: got %02h expected 82", v); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        bus_write(4'h1, 8'h0F);
        ticks(8);
        bus_write(4'h2, 8'hFF);
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'h08) begin n_err++; $display("[TB] FAIL b2b_first: got %02h expected 08", v); end
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h04) begin n_err++; $display("[TB] FAIL b2b_accept: got %02h expected 04", v); end
        ticks(9);
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'hAA) begin n_err++; $display("[TB] FAIL b2b_second: got %02h expected aa", v); end
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h10) begin n_err++; $display("[TB] FAIL b2b_status: got %02h expected 10", v); end
    endtask

    task automatic test_reset_mid_conv();
        logic [7:0] v;
        bus_write(4'h1, 8'hAA);
        ticks(3);
        rst = 1'b1;
        tick();
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("[TB] FAIL rstconv_status: got %02h expected 00", v); end
        n_cmp++;
        if (uo_out !== 8'h00) begin n_err++; $display("[TB] FAIL rstconv_uo: got %02h expected 00", uo_out); end
        rst = 1'b0;
        ticks(10);
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h00) begin n_err++; $display("[TB] FAIL rstconv_after: got %02h expected 00", v); end
    endtask

`ifdef GRAY_SCHED_PMOD_EN
    task automatic test_pmod();
        logic [7:0] v;
        ui_in = 8'h00;
        bus_write(4'h6, 8'h01);
        bus_read(4'h6, v); n_cmp++;
        if (v !== 8'h01) begin n_err++; $display("[TB] FAIL pmod_ctrl: got %02h expected 01", v); end
        ui_in = 8'hC0;
        tick();
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h08) begin n_err++; $display("[TB] FAIL pmod_pending: got %02h expected 08", v); end
        tick();
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h03) begin n_err++; $display("[TB] FAIL pmod_owner: got %02h expected 03", v); end
        ticks(8);
        bus_read(4'h4, v); n_cmp++;
        if (v !== 8'h7F) begin n_err++; $display("[TB] FAIL pmod_pos: got %02h expected 7f", v); end
    endtask

    task automatic test_tie();
        logic [7:0] v;
        rst = 1'b1; ui_in = 8'h00;
        tick();
        rst = 1'b0;
        bus_write(4'h6, 8'h01);
        ui_in = 8'h55;
        bus_write(4'h1, 8'h5A);
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h0C) begin n_err++; $display("[TB] FAIL tie_both: got %02h expected 0c", v); end
        tick();
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h09) begin n_err++; $display("[TB] FAIL tie_cpu_first: got %02h expected 09", v); end
        ticks(8);
        bus_read(4'h3, v); n_cmp++;
        if (v !== 8'h77) begin n_err++; $display("[TB] FAIL tie_cpu_result: got %02h expected 77", v); end
        tick();
        bus_read(4'h0, v); n_cmp++;
        if (v !== 8'h13) begin n_err++; $display("[TB] FAIL tie_pmod_grant: got %02h expected 13", v); end
        ticks(8);
        bus_read(4'h4, v); n_cmp++;
        if (v !== 8'h66) begin n_err++; $display("[TB] FAIL tie_pmod_pos: got %02h expected 66", v); end
    endtask
`endif

    task automatic test_random();
        logic [7:0] v;
        int pick;
        for (int cyc = 0; cyc < 600; cyc++) begin
            pick = $urandom_range(0, 99);
            if (pick < 8) ui_in = 8'($urandom);
            data_write = 1'b0;
            address    = 4'($urandom_range(0, 15));
            data_in    = 8'($urandom);
            if (pick >= 55) begin
                data_write = 1'b1;
                case ($urandom_range(0, 9))
                    0:       address = 4'h0;
                    1, 2:    address = 4'h1;
                    3, 4:    address = 4'h2;
                    5:       address = 4'h3;
                    6, 7:    address = 4'h6;
                    8:       address = 4'h4;
                    default: address = 4'h7;
                endcase
            end
            tick();
            data_write = 1'b0;
            bus_read(4'h0, v); n_cmp++;
            if (v !== m_status()) begin
                n_err++; $display("[TB] FAIL rnd_status cyc %0d: got %02h expected %02h", cyc, v, m_status());
            end
            bus_read(4'h3, v); n_cmp++;
            if (v !== m_result || uo_out !== m_result) begin
                n_err++; $display("[TB] FAIL rnd_result cyc %0d: got %02h/%02h expected %02h", cyc, v, uo_out, m_result);
            end
            bus_read(4'h4, v); n_cmp++;
            if (v !== {1'b0, m_pos}) begin
                n_err++; $display("[TB] FAIL rnd_pos cyc %0d: got %02h expected %02h", cyc, v, {1'b0, m_pos});
            end
            bus_read(4'h6, v); n_cmp++;
            if (v !== {7'b0, m_pmod_en}) begin
                n_err++; $display("[TB] FAIL rnd_ctrl cyc %0d: got %02h expected %02h", cyc, v, {7'b0, m_pmod_en});
            end
        end
    endtask

    initial begin
        rst = 1'b1; ui_in = 8'h00; address = 4'h0; data_write = 1'b0; data_in = 8'h00;
        model_reset();
        test_reset();
        test_cpu_b2g();
        test_overrun();
        test_clear_abort();
        test_back_to_back();
        test_reset_mid_conv();
`ifdef GRAY_SCHED_PMOD_EN
        test_pmod();
        test_tie();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
